wb_write_arbiter: RTL and testbench
===================================

# wb_write_arbiter

Writeback-port arbiter in front of the GPR write port. Merges the in-order pipeline writeback stream with results from long-latency units (divider, load-miss return) into the single `regWrite/rw/Wd` write port. Queues secondary results in a small FIFO and squashes stale queued writes (WAW). Exposes a pending-register mask and a starvation stall request to the hazard unit.

## Interface
Parameters:
- `DEPTH`, 4: secondary FIFO entries, power of two, 2..8.
- `STARVE_MAX`, 3: consecutive lost-arbitration cycles before `stall_req` asserts, 1..15.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `p_valid`  in  1  primary (pipeline WB) write request; no backpressure.
- `p_rw`  in  5  primary destination register.
- `p_wd`  in  32  primary write data.
- `s_valid`  in  1  secondary result valid.
- `s_ready`  out  1  secondary accept; transfer when `s_valid && s_ready`.
- `s_rw`  in  5  secondary destination register.
- `s_wd`  in  32  secondary write data.
- `regWrite`  out  1  GPR write enable, registered.
- `rw`  out  5  GPR write address, registered.
- `Wd`  out  32  GPR write data, registered.
- `pend_mask`  out  32  bit i set when a live FIFO entry targets register i.
- `stall_req`  out  1  asks the hazard unit to hold `p_valid` low.

## Operation
- Requests with destination 0 are dropped: primary `p_rw==0` is treated as idle. Secondary `s_rw==0` is accepted but not stored.
- Secondary results are older in program order than any concurrent or later primary write.
- Arbitration each cycle, in priority order:
  - `p_valid && p_rw!=0`: primary is written.
  - Otherwise, if the FIFO head is live: pop the head and write it.
  - Otherwise: `regWrite=0`.
- Exception: while `stall_req=1` the FIFO head wins. If `p_valid` is asserted anyway, primary still wins; losing primary data is never allowed.
- FIFO:
  - `s_ready = !reset && (count < DEPTH)`. Combinational, from registered state only.
  - A push and a pop in the same cycle are legal at any occupancy below DEPTH. When full, `s_ready=0` even if a pop occurs this cycle.
  - Pointers wrap modulo DEPTH.
- WAW squash: when primary writes register X, every live FIFO entry with `rw==X` is marked dead in the same cycle. This includes an entry being pushed that cycle.
  - Dead entries are popped silently, consume one arbitration slot, and produce `regWrite=0`.
  - Dead entries are excluded from `pend_mask`.
- `pend_mask` is the OR of one-hot(`rw`) over live entries; bit 0 is always 0.
- Starvation counter:
  - Increments each cycle the FIFO is non-empty and the head loses to primary.
  - Clears on any pop or when the FIFO is empty.
  - `stall_req` is registered; it asserts the cycle after the counter reaches STARVE_MAX and deasserts the cycle after the pop.

## Timing
- Reset values: `regWrite=0`, `rw=0`, `Wd=0`, `pend_mask=0`, `stall_req=0`, FIFO empty, counter 0. `s_ready=0` while `reset` is high.
- Reset asserted mid-operation discards all queued entries. No GPR write occurs in the cycle after reset.
- Primary latency: request in cycle N appears on `regWrite/rw/Wd` in N+1.
- Secondary latency: minimum 2 cycles (push in N, pop in N+1, write visible in N+2).
- `pend_mask` reflects a push from cycle N in N+1. It clears the same cycle the popped entry's write becomes visible on the outputs.
- Output registers hold their values when idle; only `regWrite` drops to 0.

## Configuration
- `WB_BYPASS_EN` defined: when the FIFO is empty, primary is idle, and `s_valid && s_rw!=0`, the secondary result goes straight to the output registers without entering the FIFO.
  - Latency is 1 cycle in that case.
  - `pend_mask` does not flag the bypassed write.
- `WB_BYPASS_EN` undefined: every secondary result goes through the FIFO, with a minimum latency of 2.

## Test plan
- **Reset:** hold `reset` 2 cycles with `s_valid=1` -> `s_ready=0`, all outputs 0. Release -> `s_ready=1`.
- **Primary write:** `p_valid=1`, `p_rw=5`, `p_wd=0xDEADBEEF` in cycle N -> `regWrite=1`, `rw=5`, `Wd=0xDEADBEEF` in N+1. A primary request with `p_rw=0` -> `regWrite=0`.
- **Fill and drain:** push 4 secondary results (`rw` 1..4) while `p_valid=1` to reg 10 every cycle.
  - `s_ready` drops after the 4th push; `pend_mask=0x1E`.
  - `stall_req` rises after 3 lost cycles.
  - Drop `p_valid` -> entries written in order 1,2,3,4; `pend_mask` returns to 0.
- **WAW squash:** queue `s_rw=7`, `s_wd=0x11`, then primary `p_rw=7`, `p_wd=0x22` before the pop -> only the 0x22 write to reg 7 appears; `pend_mask[7]` clears.
  - Repeat with the push and the primary write in the same cycle -> same result.
- **Wrap and simultaneous:** push and pop on the same cycle for 10 consecutive cycles -> data in order, no loss or duplication, count stays constant.
- **Bypass:** empty FIFO, idle primary, `s_rw=3`, `s_wd=0x55` in N.
  - With `WB_BYPASS_EN`: write visible in N+1.
  - Without it: write visible in N+2.

Source files
------------

// File: rtl/wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// wb_write_arbiter
//
// Merges the in-order pipeline writeback stream (primary) with results from
// long-latency units (secondary) onto the single GPR write port. Secondary
// results wait in a small FIFO. A primary write to register X kills every
// queued entry that targets X, because the queued result is older and would
// otherwise overwrite the newer value (WAW). The hazard unit sees a mask of
// registers with writes still in flight, plus a stall request when the FIFO
// head has lost arbitration for too long.
//
// Parameters:
//   DEPTH       secondary FIFO entries (power of two, 2..8)
//   STARVE_MAX  consecutive lost cycles before stall_req asserts (1..15)
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset
//   p_valid    in   primary write request (no backpressure)
//   p_rw       in   primary destination register (0 = idle)
//   p_wd       in   primary write data
//   s_valid    in   secondary result valid
//   s_ready    out  secondary accept (transfer on s_valid && s_ready)
//   s_rw       in   secondary destination register (0 = accepted, dropped)
//   s_wd       in   secondary write data
//   regWrite   out  GPR write enable, registered
//   rw         out  GPR write address, registered (holds when idle)
//   Wd         out  GPR write data, registered (holds when idle)
//   pend_mask  out  bit i set while a live FIFO entry targets register i
//   stall_req  out  registered request to hold p_valid low
//
// Build option:
//   WB_BYPASS_EN  when defined, a secondary result arriving with the FIFO
//                 empty and the primary idle goes straight to the output
//                 registers (1-cycle latency) without entering the FIFO.
// ---------------------------------------------------------------------------
module wb_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_valid,
    input  logic [4:0]  p_rw,
    input  logic [31:0] p_wd,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_rw,
    input  logic [31:0] s_wd,
    output logic        regWrite,
    output logic [4:0]  rw,
    output logic [31:0] Wd,
    output logic [31:0] pend_mask,
    output logic        stall_req
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_C   = CNT_W'(DEPTH);
    localparam logic [3:0]       STARVE_C = 4'(STARVE_MAX);

    // FIFO storage and bookkeeping
    logic [4:0]       fifo_rw_q [DEPTH];
    logic [31:0]      fifo_wd_q [DEPTH];
    logic [DEPTH-1:0] live_q, live_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Starvation tracking
    logic [3:0] starve_q, starve_d;
    logic       stall_q, stall_d;

    // Output port registers
    logic        out_we_q, out_we_d;
    logic [4:0]  out_rw_q, out_rw_d;
    logic [31:0] out_wd_q, out_wd_d;

    logic p_act, fifo_empty, push, store, pop, head_live, bypass;
    logic [31:0] pend_c;

    assign p_act      = p_valid && (p_rw != 5'd0);
    assign fifo_empty = (count_q == '0);
    // Depends only on registered occupancy so s_ready has no path from
    // this cycle's pops; a full FIFO refuses even if it drains this cycle.
    assign s_ready    = !reset && (count_q < FULL_C);
    assign push       = s_valid && s_ready;
    // The head pops whenever primary does not claim the port, live or not:
    // a dead head still burns its slot but produces no GPR write.
    assign pop        = !fifo_empty && !p_act;
    assign head_live  = live_q[rd_ptr_q];

`ifdef WB_BYPASS_EN
    assign bypass = push && fifo_empty && !p_act && (s_rw != 5'd0);
`else
    assign bypass = 1'b0;
`endif

    // Register 0 results are acknowledged but never queued.
    assign store = push && (s_rw != 5'd0) && !bypass;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        live_d   = live_q;
        out_we_d = 1'b0;
        out_rw_d = out_rw_q;
        out_wd_d = out_wd_q;

        if (p_act) begin
            out_we_d = 1'b1;
            out_rw_d = p_rw;
            out_wd_d = p_wd;
        end else if (pop && head_live) begin
            out_we_d = 1'b1;
            out_rw_d = fifo_rw_q[rd_ptr_q];
            out_wd_d = fifo_wd_q[rd_ptr_q];
        end else if (bypass) begin
            out_we_d = 1'b1;
            out_rw_d = s_rw;
            out_wd_d = s_wd;
        end

        // WAW squash of queued entries that are older than the primary write.
        for (int i = 0; i < DEPTH; i++) begin
            if (p_act && live_q[i] && (fifo_rw_q[i] == p_rw)) begin
                live_d[i] = 1'b0;
            end
        end

        if (pop) begin
            live_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = rd_ptr_q + PTR_W'(1);
        end

        // An entry pushed alongside a primary write to the same register is
        // already stale, so it enters the FIFO dead.
        if (store) begin
            live_d[wr_ptr_q] = !(p_act && (s_rw == p_rw));
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end

        case ({store, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Counts consecutive cycles the head loses to primary, saturating at
    // STARVE_MAX; stall_req follows the next counter value so it rises the
    // cycle after the limit is hit and falls the cycle after the pop.
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = 4'd0;
        end else if (starve_q != STARVE_C) begin
            starve_d = starve_q + 4'd1;
        end
        stall_d = (starve_d == STARVE_C);
    end

    always_comb begin
        pend_c = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live_q[i]) begin
                pend_c[fifo_rw_q[i]] = 1'b1;
            end
        end
        pend_c[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            live_q   <= '0;
            starve_q <= 4'd0;
            stall_q  <= 1'b0;
            out_we_q <= 1'b0;
            out_rw_q <= 5'd0;
            out_wd_q <= 32'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            live_q   <= live_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
            out_we_q <= out_we_d;
            out_rw_q <= out_rw_d;
            out_wd_q <= out_wd_d;
        end
    end

    // NOTE: payload storage is not reset; an entry is only ever read while
    // its slot is occupied, and occupancy/live bits are reset above.
    always_ff @(posedge clk) begin
        if (store) begin
            fifo_rw_q[wr_ptr_q] <= s_rw;
            fifo_wd_q[wr_ptr_q] <= s_wd;
        end
    end

    assign regWrite  = out_we_q;
    assign rw        = out_rw_q;
    assign Wd        = out_wd_q;
    assign pend_mask = pend_c;
    assign stall_req = stall_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_write_arbiter
//
// Directed testbench for wb_write_arbiter (DEPTH=4, STARVE_MAX=3). Inputs
// are driven 1 time unit after each rising edge; outputs are sampled at the
// same point, so each step() shows the effect of the inputs applied before
// that edge. Expected values are written out by hand.
// ---------------------------------------------------------------------------
module tb_wb_write_arbiter;

    logic        clk;
    logic        reset;
    logic        p_valid;
    logic [4:0]  p_rw;
    logic [31:0] p_wd;
    logic        s_valid;
    logic        s_ready;
    logic [4:0]  s_rw;
    logic [31:0] s_wd;
    logic        regWrite;
    logic [4:0]  rw;
    logic [31:0] Wd;
    logic [31:0] pend_mask;
    logic        stall_req;

    int n_tests = 0;
    int n_fail  = 0;

    wb_write_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .p_valid   (p_valid),
        .p_rw      (p_rw),
        .p_wd      (p_wd),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_rw      (s_rw),
        .s_wd      (s_wd),
        .regWrite  (regWrite),
        .rw        (rw),
        .Wd        (Wd),
        .pend_mask (pend_mask),
        .stall_req (stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_seen(input string tag, input logic [4:0] exp_rw, input logic [31:0] exp_wd);
        check({tag, " regWrite"}, 32'(regWrite), 32'd1);
        check({tag, " rw"},       32'(rw),       32'(exp_rw));
        check({tag, " Wd"},       Wd,            exp_wd);
    endtask

    initial begin
        reset   = 1'b1;
        p_valid = 1'b0;
        p_rw    = 5'd0;
        p_wd    = 32'd0;
        s_valid = 1'b1;
        s_rw    = 5'd9;
        s_wd    = 32'h99;

        // ---------------- reset ----------------
        step();
        step();
        check("rst s_ready",   32'(s_ready),   32'd0);
        check("rst regWrite",  32'(regWrite),  32'd0);
        check("rst rw",        32'(rw),        32'd0);
        check("rst Wd",        Wd,             32'd0);
        check("rst pend_mask", pend_mask,      32'd0);
        check("rst stall_req", 32'(stall_req), 32'd0);
        reset   = 1'b0;
        s_valid = 1'b0;
        #1;
        check("rel s_ready",   32'(s_ready),   32'd1);

        // ---------------- primary write ----------------
        p_valid = 1'b1; p_rw = 5'd5; p_wd = 32'hDEADBEEF;
        step();
        write_seen("prim", 5'd5, 32'hDEADBEEF);
        p_rw = 5'd0; p_wd = 32'h1234;
        step();
        check("prim r0 regWrite", 32'(regWrite), 32'd0);
        check("prim hold rw",     32'(rw),       32'd5);
        check("prim hold Wd",     Wd,            32'hDEADBEEF);

        // ---------------- fill and drain ----------------
        p_valid = 1'b1; p_rw = 5'd10; p_wd = 32'hA0;
        for (int k = 1; k <= 4; k++) begin
            s_valid = 1'b1; s_rw = 5'(k); s_wd = 32'h100 + 32'(k);
            step();
            write_seen("fill prim", 5'd10, 32'hA0);
            if (k == 3) check("fill stall before limit", 32'(stall_req), 32'd0);
        end
        check("full s_ready",   32'(s_ready),   32'd0);
        check("full pend_mask", pend_mask,      32'h0000_001E);
        check("full stall_req", 32'(stall_req), 32'd1);
        // Offer a fifth result while full: must be refused.
        s_rw = 5'd5; s_wd = 32'h105;
        step();
        check("full refuse pend", pend_mask,      32'h0000_001E);
        check("full stall hold",  32'(stall_req), 32'd1);
        s_valid = 1'b0;
        p_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            write_seen("drain", 5'(k), 32'h100 + 32'(k));
            check("drain pend", pend_mask, 32'h1E & ~((32'd1 << (k + 1)) - 32'd1));
            check("drain stall", 32'(stall_req), 32'd0);
        end
        check("drain s_ready", 32'(s_ready), 32'd1);
        step();
        check("drain idle", 32'(regWrite), 32'd0);

        // ---------------- WAW squash, separate cycles ----------------
        p_valid = 1'b1; p_rw = 5'd12; p_wd = 32'hC;
        s_valid = 1'b1; s_rw = 5'd7;  s_wd = 32'h11;
        step();
        check("waw1 queued pend", pend_mask, 32'h0000_0080);
        s_valid = 1'b0;
        p_rw = 5'd7; p_wd = 32'h22;
        step();
        write_seen("waw1 prim", 5'd7, 32'h22);
        check("waw1 pend cleared", pend_mask, 32'd0);
        p_valid = 1'b0;
        step();
        check("waw1 dead pop regWrite", 32'(regWrite), 32'd0);
        check("waw1 dead pop Wd",       Wd,            32'h22);
        step();
        check("waw1 idle regWrite", 32'(regWrite), 32'd0);

        // ---------------- WAW squash, same cycle ----------------
        p_valid = 1'b1; p_rw = 5'd7; p_wd = 32'h44;
        s_valid = 1'b1; s_rw = 5'd7; s_wd = 32'h33;
        step();
        write_seen("waw2 prim", 5'd7, 32'h44);
        check("waw2 pend", pend_mask, 32'd0);
        p_valid = 1'b0; s_valid = 1'b0;
        step();
        check("waw2 dead pop regWrite", 32'(regWrite), 32'd0);
        check("waw2 dead pop Wd",       Wd,            32'h44);

        // ---------------- wrap with simultaneous push/pop ----------------
        p_valid = 1'b1; p_rw = 5'd12; p_wd = 32'hC;
        s_valid = 1'b1; s_rw = 5'd16; s_wd = 32'h200;
        step();
        check("wrap prefill pend", pend_mask, 32'h0001_0000);
        p_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            s_rw = 5'(16 + k); s_wd = 32'h200 + 32'(k);
            step();
            write_seen("wrap", 5'(16 + k - 1), 32'h200 + 32'(k - 1));
            check("wrap pend", pend_mask, 32'd1 << (16 + k));
            check("wrap s_ready", 32'(s_ready), 32'd1);
        end
        s_valid = 1'b0;
        step();
        write_seen("wrap last", 5'd26, 32'h20A);
        check("wrap pend empty", pend_mask, 32'd0);
        step();
        check("wrap idle", 32'(regWrite), 32'd0);

        // ---------------- secondary to register 0 ----------------
        s_valid = 1'b1; s_rw = 5'd0; s_wd = 32'h77;
        #1;
        check("r0 s_ready", 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
        check("r0 pend", pend_mask, 32'd0);
        step();
        check("r0 no write", 32'(regWrite), 32'd0);

        // ---------------- bypass / minimum latency ----------------
        s_valid = 1'b1; s_rw = 5'd3; s_wd = 32'h55;
        step();
        s_valid = 1'b0;
`ifdef WB_BYPASS_EN
        write_seen("bypass N+1", 5'd3, 32'h55);
        check("bypass pend", pend_mask, 32'd0);
        step();
        check("bypass done", 32'(regWrite), 32'd0);
`else
        check("nobypass N+1 regWrite", 32'(regWrite), 32'd0);
        check("nobypass N+1 pend",     pend_mask,      32'h0000_0008);
        step();
        write_seen("nobypass N+2", 5'd3, 32'h55);
        check("nobypass N+2 pend", pend_mask, 32'd0);
`endif

        // ---------------- reset mid-operation ----------------
        p_valid = 1'b1; p_rw = 5'd12; p_wd = 32'hC;
        s_valid = 1'b1;
        s_rw = 5'd20; s_wd = 32'h300;
        step();
        s_rw = 5'd21; s_wd = 32'h301;
        step();
        check("midrst queued pend", pend_mask, 32'h0030_0000);
        p_valid = 1'b0; s_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midrst s_ready", 32'(s_ready), 32'd0);
        step();
        check("midrst regWrite", 32'(regWrite), 32'd0);
        check("midrst rw",       32'(rw),       32'd0);
        check("midrst pend",     pend_mask,     32'd0);
        reset = 1'b0;
        step();
        check("midrst no write after", 32'(regWrite), 32'd0);
        check("midrst s_ready after",  32'(s_ready),  32'd1);
        check("midrst pend after",     pend_mask,     32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
